// File: rtl/stack_store_unit.sv
// stack_store_unit: write-side sequencer for byte stores and 6502 stack pushes.
// It accepts one request at a time and emits one memory write per phi1 cycle.
// Stack writes go to descending addresses within the stack page.
// A single-cycle DONE state returns the updated stack pointer to the register file.
module stack_store_unit #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [1:0]            req_kind,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]  req_data,
    input  logic [ADDR_WIDTH-1:0] req_word,
    input  logic [REG_WIDTH-1:0]  sp_in,
    output logic                  req_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [REG_WIDTH-1:0]  wr_data,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic                  sp_we,
    output logic                  write_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        KIND_STORE  = 2'd0,
        KIND_PUSH8  = 2'd1,
        KIND_PUSH16 = 2'd2,
        KIND_PUSH24 = 2'd3
    } kind_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        W1   = 3'd2,
        W2   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state;
    kind_t                kind_q;
    logic [REG_WIDTH-1:0] sp_q;
    logic [REG_WIDTH-1:0] data_q;
    logic [REG_WIDTH-1:0] pcl_q;

    logic [REG_WIDTH-1:0] sp_m1;
    logic [REG_WIDTH-1:0] sp_m2;
    logic [REG_WIDTH-1:0] sp_m3;

    // The stack pointer wraps within its own width, so the page byte never changes.
    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] sp);
        return STACK_BASE + ADDR_WIDTH'(sp);
    endfunction

    // Decremented stack pointers for the second and third push bytes and the final SP.
    always_comb begin
        sp_m1 = sp_q - REG_WIDTH'(1);
        sp_m2 = sp_q - REG_WIDTH'(2);
        sp_m3 = sp_q - REG_WIDTH'(3);
    end

    // Sequencer: the first write is set up on the accept edge so wr_en rises right away.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            kind_q     <= KIND_STORE;
            sp_q       <= '0;
            data_q     <= '0;
            pcl_q      <= '0;
            req_ready  <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            sp_out     <= '0;
            sp_we      <= 1'b0;
            write_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        kind_q    <= kind_t'(req_kind);
                        sp_q      <= sp_in;
                        data_q    <= req_data;
                        pcl_q     <= req_word[REG_WIDTH-1:0];
                        state     <= W0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        wr_en     <= 1'b1;
                        case (kind_t'(req_kind))
                            KIND_STORE: begin
                                wr_addr <= req_addr;
                                wr_data <= req_data;
                            end
                            KIND_PUSH8: begin
                                wr_addr <= stack_addr(sp_in);
                                wr_data <= req_data;
                            end
                            default: begin
                                wr_addr <= stack_addr(sp_in);
                                wr_data <= req_word[2*REG_WIDTH-1:REG_WIDTH];
                            end
                        endcase
                    end
                end
                W0: begin
                    if (kind_q == KIND_STORE || kind_q == KIND_PUSH8) begin
                        state      <= DONE;
                        wr_en      <= 1'b0;
                        write_done <= 1'b1;
                        if (kind_q == KIND_PUSH8) begin
                            sp_we  <= 1'b1;
                            sp_out <= sp_m1;
                        end
                    end else begin
                        state   <= W1;
                        wr_addr <= stack_addr(sp_m1);
                        wr_data <= pcl_q;
                    end
                end
                W1: begin
                    if (kind_q == KIND_PUSH16) begin
                        state      <= DONE;
                        wr_en      <= 1'b0;
                        write_done <= 1'b1;
                        sp_we      <= 1'b1;
                        sp_out     <= sp_m2;
                    end else begin
                        state   <= W2;
                        wr_addr <= stack_addr(sp_m2);
                        wr_data <= data_q;
                    end
                end
                W2: begin
                    state      <= DONE;
                    wr_en      <= 1'b0;
                    write_done <= 1'b1;
                    sp_we      <= 1'b1;
                    sp_out     <= sp_m3;
                end
                DONE: begin
                    state      <= IDLE;
                    write_done <= 1'b0;
                    sp_we      <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
